// File: rtl/pvt_delay_sequencer.sv
// ---------------------------------------------------------------------------
// pvt_delay_sequencer
//
// Sequences repeated measurements of a clk-to-q + setup delay-chain monitor.
// Each run pulses the chain start, records the monitor's free-running
// counter, waits for a fresh rising edge on the chain event tap and
// accumulates the counter difference. After 2**AVG_LOG2 runs the truncated
// average is offered on a valid/ready port. A run that sees no event within
// TIMEOUT cycles aborts the whole batch and reports result_tout with data 0.
//
// Ports
//   clk           measurement clock, all logic on posedge
//   rst           asynchronous active-high reset
//   trig          request one averaged measurement (honoured in IDLE only)
//   meas_start    one-cycle start pulse to the delay-chain monitor
//   measured_cnt  monitor free-running counter
//   meas_event    delay-chain event tap, rising edge ends a run
//   busy          high whenever the sequencer is not idle
//   result_data   averaged counter delta (0 when timed out)
//   result_tout   batch aborted on timeout
//   result_valid  result qualifier
//   result_ready  consumer accepts on valid & ready
// ---------------------------------------------------------------------------
module pvt_delay_sequencer #(
  parameter int CNT_WIDTH = 8,
  parameter int AVG_LOG2  = 2,
  parameter int TIMEOUT   = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  output logic                 meas_start,
  input  logic [CNT_WIDTH-1:0] measured_cnt,
  input  logic                 meas_event,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] result_data,
  output logic                 result_tout,
  output logic                 result_valid,
  input  logic                 result_ready
);

  // Accumulator is wide enough to hold 2**AVG_LOG2 full-scale deltas.
  localparam int ACC_WIDTH = CNT_WIDTH + AVG_LOG2;
  // Keep the run index at least one bit wide so AVG_LOG2 = 0 still elaborates.
  localparam int RUN_WIDTH = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [RUN_WIDTH-1:0] LAST_RUN  = RUN_WIDTH'((1 << AVG_LOG2) - 1);
  localparam logic [RUN_WIDTH-1:0] RUN_ONE   = RUN_WIDTH'(1);
  localparam logic [RUN_WIDTH-1:0] RUN_ZERO  = RUN_WIDTH'(0);
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO  = ACC_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [15:0]          WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [RUN_WIDTH-1:0]   run_idx_q, run_idx_d;
  logic [15:0]            wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]   cnt0_q, cnt0_d;
  logic                   ev_q, ev_d;
  logic                   meas_start_q, meas_start_d;
  logic                   busy_q, busy_d;
  logic                   result_valid_q, result_valid_d;
  logic [CNT_WIDTH-1:0]   result_data_q, result_data_d;
  logic                   result_tout_q, result_tout_d;

  logic                   rise;
  logic                   last_run;
  logic                   wait_expired;
  logic [CNT_WIDTH-1:0]   delta;
  logic [ACC_WIDTH-1:0]   acc_sum;

  // Only a fresh 0->1 relative to the previous sampled tap ends a run.
  assign rise         = meas_event & ~ev_q;
  assign last_run     = (run_idx_q == LAST_RUN);
  assign wait_expired = (wait_cnt_q == WAIT_LAST);
  // Modular subtraction makes a counter wrap between start and event harmless.
  assign delta        = measured_cnt - cnt0_q;
  assign acc_sum      = acc_q + ACC_WIDTH'(delta);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an event rise wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rise) begin
          if (last_run) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
          end
        end else if (wait_expired) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (result_valid_q && result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and output next values; outputs are decoded from the next state
  // so that the registered copies line up with the state they describe.
  always_comb begin
    acc_d          = acc_q;
    run_idx_d      = run_idx_q;
    wait_cnt_d     = wait_cnt_q;
    cnt0_d         = cnt0_q;
    ev_d           = ev_q;
    result_data_d  = result_data_q;
    result_tout_d  = result_tout_q;
    meas_start_d   = (state_d == S_START);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        acc_d     = ACC_ZERO;
        run_idx_d = RUN_ZERO;
      end
      S_START: begin
        cnt0_d     = measured_cnt;
        ev_d       = meas_event;
        wait_cnt_d = 16'd0;
      end
      S_WAIT: begin
        ev_d = meas_event;
        if (rise) begin
          acc_d = acc_sum;
          if (last_run) begin
            result_data_d = acc_sum[ACC_WIDTH-1:AVG_LOG2];
            result_tout_d = 1'b0;
          end else begin
            run_idx_d = run_idx_q + RUN_ONE;
          end
        end else if (wait_expired) begin
          result_data_d = CNT_ZERO;
          result_tout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        // Result registers hold until the next batch completes.
        result_data_d = result_data_q;
      end
      default: begin
        acc_d     = ACC_ZERO;
        run_idx_d = RUN_ZERO;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q          <= ACC_ZERO;
      run_idx_q      <= RUN_ZERO;
      wait_cnt_q     <= 16'd0;
      cnt0_q         <= CNT_ZERO;
      ev_q           <= 1'b0;
      meas_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_data_q  <= CNT_ZERO;
      result_tout_q  <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      run_idx_q      <= run_idx_d;
      wait_cnt_q     <= wait_cnt_d;
      cnt0_q         <= cnt0_d;
      ev_q           <= ev_d;
      meas_start_q   <= meas_start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      result_tout_q  <= result_tout_d;
    end
  end

  assign meas_start   = meas_start_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign result_tout  = result_tout_q;

endmodule
